// File: rtl/gigatron_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : gigatron_pkg                                               |
// | Shared constants and types for the Gigatron input-port source.       |
// | Contents: video sync bit positions, idle input byte, controller      |
// |           button bit indices, key-injection FSM state encoding.      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package gigatron_pkg;

  // Bit positions inside the core's 8-bit video port (both active-low).
  localparam int VGA_HSYNC = 6;
  localparam int VGA_VSYNC = 7;

  // Byte seen by software when nothing is pressed.
  localparam logic [7:0] INREG_IDLE = 8'hFF;

  // Controller button bit indices (active-low in the input byte).
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  // Key-injection FSM states.
  typedef enum logic [1:0] {
    KEY_IDLE    = 2'd0,
    KEY_HOLD    = 2'd1,
    KEY_RELEASE = 2'd2
  } key_state_e;

endpackage : gigatron_pkg
`default_nettype wire

// File: rtl/gigatron_pad_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gigatron_pad_shifter                                       |
// | Serial game-controller model clocked by the core's sync bits.        |
// | A vsync fall loads the source word; each hsync rise during vsync low |
// | shifts one bit across; a vsync rise after 8 bits transfers the byte  |
// | to the output and pulses the frame strobe.                           |
// | Ports:                                                               |
// |   clk_i, rst_i      clock, synchronous active-high reset             |
// |   hsync_i, vsync_i  live sync bits (active-low)                      |
// |   src_word_i        word loaded at vsync fall                        |
// |   src_tag_i         tag latched with the word                        |
// |   inreg_o           byte presented to the core                       |
// |   frame_strobe_o    one-cycle pulse per complete frame               |
// |   frame_tag_o       tag of the frame just completed                  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module gigatron_pad_shifter
  import gigatron_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic [7:0] src_word_i,
  input  logic       src_tag_i,
  output logic [7:0] inreg_o,
  output logic       frame_strobe_o,
  output logic       frame_tag_o
);

  localparam logic [3:0] BITS_PER_FRAME = 4'd8;

  logic       hs_q, vs_q;
  logic [7:0] ctl_sr_q, ctl_sr_d;
  logic [7:0] in_sr_q, in_sr_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic       tag_q, tag_d;
  logic [7:0] inreg_q, inreg_d;
  logic       strobe_q, strobe_d;

  logic vs_fall, vs_rise, hs_rise, shift_en;

  always_comb begin
    vs_fall  = vs_q & ~vsync_i;
    vs_rise  = ~vs_q & vsync_i;
    hs_rise  = ~hs_q & hsync_i;
    // vs_q (not the live bit) qualifies the shift so that an hsync rise in
    // the same cycle as the vsync rise still lands before the transfer.
    shift_en = hs_rise & ~vs_q & (bitcnt_q != BITS_PER_FRAME);
  end

  always_comb begin
    ctl_sr_d = ctl_sr_q;
    in_sr_d  = in_sr_q;
    bitcnt_d = bitcnt_q;
    tag_d    = tag_q;
    inreg_d  = inreg_q;
    strobe_d = 1'b0;

    if (vs_fall) begin
      // Load takes priority over any coincident hsync rise.
      ctl_sr_d = src_word_i;
      tag_d    = src_tag_i;
      in_sr_d  = 8'h00;
      bitcnt_d = 4'd0;
    end else begin
      if (shift_en) begin
        in_sr_d  = {in_sr_q[6:0], ctl_sr_q[7]};
        ctl_sr_d = {ctl_sr_q[6:0], 1'b1};
        bitcnt_d = bitcnt_q + 4'd1;
      end
      // Transfer looks at the post-shift values.
      if (vs_rise && (bitcnt_d == BITS_PER_FRAME)) begin
        inreg_d  = in_sr_d;
        strobe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      ctl_sr_q <= INREG_IDLE;
      in_sr_q  <= 8'h00;
      bitcnt_q <= 4'd0;
      tag_q    <= 1'b0;
      inreg_q  <= INREG_IDLE;
      strobe_q <= 1'b0;
    end else begin
      hs_q     <= hsync_i;
      vs_q     <= vsync_i;
      ctl_sr_q <= ctl_sr_d;
      in_sr_q  <= in_sr_d;
      bitcnt_q <= bitcnt_d;
      tag_q    <= tag_d;
      inreg_q  <= inreg_d;
      strobe_q <= strobe_d;
    end
  end

  assign inreg_o        = inreg_q;
  assign frame_strobe_o = strobe_q;
  // The tag only changes at the next vsync fall, so it is stable while
  // the strobe for this frame is high.
  assign frame_tag_o    = tag_q;

endmodule : gigatron_pad_shifter
`default_nettype wire

// File: rtl/gigatron_inreg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gigatron_inreg                                             |
// | Input-port byte source for the Gigatron core: serial controller      |
// | model plus a host key-injection channel. An injected byte is shown   |
// | for HOLD_FRAMES complete frames, then 0xFF for RELEASE_FRAMES.       |
// | Ports:                                                               |
// |   clock, rst        core clock, synchronous active-high reset        |
// |   vga[7:0]          core video port (bit 6 hsync, bit 7 vsync)       |
// |   pad_n[7:0]        controller buttons, active-low                   |
// |   key_data[7:0]     host byte to inject                              |
// |   key_valid         host request                                     |
// |   key_ready         request accepted this cycle                      |
// |   inreg[7:0]        byte presented to the core                       |
// |   frame_strobe      one-cycle pulse per complete frame               |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module gigatron_inreg
  import gigatron_pkg::*;
#(
  parameter int HOLD_FRAMES    = 3,
  parameter int RELEASE_FRAMES = 2
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [7:0] vga,
  input  logic [7:0] pad_n,
  input  logic [7:0] key_data,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [7:0] inreg,
  output logic       frame_strobe
);

  if ((HOLD_FRAMES < 1) || (HOLD_FRAMES > 15)) begin : g_bad_hold
    $error("gigatron_inreg: HOLD_FRAMES must be in 1..15");
  end
  if ((RELEASE_FRAMES < 1) || (RELEASE_FRAMES > 15)) begin : g_bad_release
    $error("gigatron_inreg: RELEASE_FRAMES must be in 1..15");
  end

  localparam logic [3:0] HOLD_LIM    = 4'(HOLD_FRAMES);
  localparam logic [3:0] RELEASE_LIM = 4'(RELEASE_FRAMES);

  key_state_e state_q, state_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic [7:0] key_byte_q, key_byte_d;
  logic [3:0] fcnt_inc;

  logic [7:0] src_word;
  logic       src_tag;
  logic       strobe;
  logic       strobe_tag;

  // Only the sync bits of the video port are used here.
  logic unused_vga;
  assign unused_vga = ^vga[5:0];

  // Source word for the next frame load.
  always_comb begin
    src_word = pad_n;
    src_tag  = 1'b0;
    case (state_q)
      KEY_HOLD: begin
        src_word = key_byte_q;
        src_tag  = 1'b1;
      end
      KEY_RELEASE: src_word = INREG_IDLE;
      default:     src_word = pad_n;
    endcase
  end

  gigatron_pad_shifter u_shifter (
    .clk_i          (clock),
    .rst_i          (rst),
    .hsync_i        (vga[VGA_HSYNC]),
    .vsync_i        (vga[VGA_VSYNC]),
    .src_word_i     (src_word),
    .src_tag_i      (src_tag),
    .inreg_o        (inreg),
    .frame_strobe_o (strobe),
    .frame_tag_o    (strobe_tag)
  );

  assign frame_strobe = strobe;
  assign key_ready    = (state_q == KEY_IDLE);

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    key_byte_d = key_byte_q;
    fcnt_inc   = fcnt_q + 4'd1;

    case (state_q)
      KEY_IDLE: begin
        if (key_valid) begin
          key_byte_d = key_data;
          fcnt_d     = 4'd0;
          state_d    = KEY_HOLD;
        end
      end
      KEY_HOLD: begin
        // Frames loaded before the key was accepted carry tag 0 and still
        // show pad_n, so they must not consume hold time.
        if (strobe && strobe_tag) begin
          if (fcnt_inc == HOLD_LIM) begin
            fcnt_d  = 4'd0;
            state_d = KEY_RELEASE;
          end else begin
            fcnt_d = fcnt_inc;
          end
        end
      end
      KEY_RELEASE: begin
        if (strobe) begin
          if (fcnt_inc == RELEASE_LIM) begin
            fcnt_d  = 4'd0;
            state_d = KEY_IDLE;
          end else begin
            fcnt_d = fcnt_inc;
          end
        end
      end
      default: begin
        fcnt_d  = 4'd0;
        state_d = KEY_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= KEY_IDLE;
      fcnt_q     <= 4'd0;
      key_byte_q <= INREG_IDLE;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      key_byte_q <= key_byte_d;
    end
  end

endmodule : gigatron_inreg
`default_nettype wire

// File: tb/tb_gigatron_inreg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_gigatron_inreg                                          |
// | Scoreboard bench: each complete frame pushes its expected byte, a    |
// | monitor pops and compares on every frame_strobe.                     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_gigatron_inreg;

  logic       clock = 1'b0;
  logic       rst;
  logic [7:0] vga;
  logic [7:0] pad_n;
  logic [7:0] key_data;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] inreg;
  logic       frame_strobe;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  gigatron_inreg #(.HOLD_FRAMES(3), .RELEASE_FRAMES(2)) dut (
    .clock        (clock),
    .rst          (rst),
    .vga          (vga),
    .pad_n        (pad_n),
    .key_data     (key_data),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .inreg        (inreg),
    .frame_strobe (frame_strobe)
  );

  always #5 clock = ~clock;

  // Monitor: compare every strobe against the scoreboard.
  always @(negedge clock) begin
    if (frame_strobe === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got strobe with inreg=%02h, required no strobe", inreg);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (inreg !== e) begin
          errors++;
          $display("FAIL frame_inreg: got %02h, required %02h", inreg, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %02h, required %02h", name, got, req);
    end
  endtask

  // One vsync-low window with nh hsync rises.
  task automatic frame(input int nh, input bit merge_fall, input bit merge_rise,
                       input bit inject, input bit done, input logic [7:0] e);
    if (done) exp_q.push_back(e);
    if (merge_fall) begin
      vga[6] = 1'b0;
      step(2);
      vga[7] = 1'b0;
      vga[6] = 1'b1;
    end else begin
      vga[7] = 1'b0;
    end
    step(2);
    for (int i = 0; i < nh; i++) begin
      vga[6] = 1'b0;
      step(2);
      if (merge_rise && (i == nh - 1)) vga[7] = 1'b1;
      vga[6] = 1'b1;
      step(2);
      if (inject && (i == 0)) begin
        key_data  = 8'h41;
        key_valid = 1'b1;
        step(1);
        key_valid = 1'b0;
      end
    end
    vga[7] = 1'b1;
    step(6);
  endtask

  task automatic send_key(input logic [7:0] d);
    check8("ready_before_key", {7'd0, key_ready}, 8'h01);
    key_data  = d;
    key_valid = 1'b1;
    step(1);
    key_valid = 1'b0;
    check8("ready_after_key", {7'd0, key_ready}, 8'h00);
  endtask

  initial begin
    rst       = 1'b1;
    vga       = 8'hC0;
    pad_n     = 8'hFF;
    key_data  = 8'h00;
    key_valid = 1'b0;
    step(3);
    check8("reset_inreg", inreg, 8'hFF);
    check8("reset_strobe", {7'd0, frame_strobe}, 8'h00);
    check8("reset_ready", {7'd0, key_ready}, 8'h01);
    rst = 1'b0;
    step(2);

    // Idle pad.
    frame(8, 0, 0, 0, 1, 8'hFF);

    // A and right pressed.
    pad_n = 8'h7E;
    frame(8, 0, 0, 0, 1, 8'h7E);
    check8("pad_7e", inreg, 8'h7E);
    frame(8, 0, 0, 0, 1, 8'h7E);

    // Short frame ignored, long frame saturates.
    pad_n = 8'h3C;
    frame(5, 0, 0, 0, 0, 8'h00);
    check8("short_frame_keeps", inreg, 8'h7E);
    frame(12, 0, 0, 0, 1, 8'h3C);
    check8("long_frame", inreg, 8'h3C);

    // Last hsync rise coincides with vsync rise: shift then transfer.
    pad_n = 8'hA5;
    frame(8, 0, 1, 0, 1, 8'hA5);

    // hsync rise coinciding with vsync fall is not a shift.
    pad_n = 8'h5A;
    frame(7, 1, 0, 0, 0, 8'h00);
    check8("fall_merge_incomplete", inreg, 8'hA5);
    frame(8, 1, 0, 0, 1, 8'h5A);

    // Key injection between frames.
    pad_n = 8'hE7;
    send_key(8'h41);
    frame(8, 0, 0, 0, 1, 8'h41);
    key_data  = 8'h22;   // not accepted while holding
    key_valid = 1'b1;
    step(1);
    key_valid = 1'b0;
    frame(8, 0, 0, 0, 1, 8'h41);
    frame(8, 0, 0, 0, 1, 8'h41);
    check8("ready_in_release", {7'd0, key_ready}, 8'h00);
    frame(8, 0, 0, 0, 1, 8'hFF);
    frame(8, 0, 0, 0, 1, 8'hFF);
    check8("ready_after_release", {7'd0, key_ready}, 8'h01);
    frame(8, 0, 0, 0, 1, 8'hE7);

    // Key accepted during vsync low: that frame still shows the pad.
    frame(8, 0, 0, 1, 1, 8'hE7);
    check8("ready_after_inject", {7'd0, key_ready}, 8'h00);
    frame(8, 0, 0, 0, 1, 8'h41);
    frame(8, 0, 0, 0, 1, 8'h41);
    frame(8, 0, 0, 0, 1, 8'h41);
    frame(8, 0, 0, 0, 1, 8'hFF);
    frame(8, 0, 0, 0, 1, 8'hFF);
    frame(8, 0, 0, 0, 1, 8'hE7);

    // Reset during hold drops the key.
    send_key(8'h41);
    frame(8, 0, 0, 0, 1, 8'h41);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check8("rst_hold_inreg", inreg, 8'hFF);
    check8("rst_hold_ready", {7'd0, key_ready}, 8'h01);
    step(2);
    frame(8, 0, 0, 0, 1, 8'hE7);
    frame(8, 0, 0, 0, 1, 8'hE7);

    step(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes: got %0d frames outstanding, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gigatron_inreg
`default_nettype wire
